// File: rtl/pipeline_stage_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stage_ctrl
//   Sequencer for a 5-stage MIPS datapath. Drives a sync reset / enable pair
//   for each of the IF, ID, EXE, MEM and WB stages. It handles post-reset
//   hold-off, load-use stall bubbles, taken-branch flushes and debug
//   halt / single-step. It also keeps saturating stall and flush event
//   counters and a sticky stall-deadlock flag.
//
// Ports
//   i_clk            clock, all state updates on posedge
//   i_rst            asynchronous active-high reset
//   i_reg_stall      ID hazard: the instruction in ID must wait
//   i_branch_taken   branch in MEM resolved taken this cycle
//   i_debug_en       1 = halt pipeline
//   i_debug_step     debug step level; each 0->1 edge advances one cycle
//   o_<stg>_rst      per-stage synchronous reset (stg = if/id/exe/mem/wb)
//   o_<stg>_en       per-stage enable
//   o_stall_cnt      applied-stall cycle count, saturating
//   o_flush_cnt      applied-flush count, saturating
//   o_deadlock_err   sticky: stall held more than STALL_MAX consecutive
//                    applied cycles
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | post-reset hold-off, every stage held in reset
//   ST_RUN  | normal operation, advances every cycle unless debug_en
//   ST_HALT | debug halt, advances only on a debug_step rising edge
// ----------------------------------------------------------------------------
module pipeline_stage_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16,
  parameter int STALL_MAX  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_reg_stall,
  input  logic             i_branch_taken,
  input  logic             i_debug_en,
  input  logic             i_debug_step,
  output logic             o_if_rst,
  output logic             o_if_en,
  output logic             o_id_rst,
  output logic             o_id_en,
  output logic             o_exe_rst,
  output logic             o_exe_en,
  output logic             o_mem_rst,
  output logic             o_mem_en,
  output logic             o_wb_rst,
  output logic             o_wb_en,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_deadlock_err
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SR_W = $clog2(STALL_MAX + 2);

  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_ONE   = RC_W'(1);
  localparam logic [SR_W-1:0] SR_LIMIT = SR_W'(STALL_MAX + 1);
  localparam logic [SR_W-1:0] SR_MAX   = SR_W'(STALL_MAX);
  localparam logic [SR_W-1:0] SR_ONE   = SR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [RC_W-1:0]  r_rst_ctr;
  logic [SR_W-1:0]  r_stall_run;
  logic             r_step_q;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_deadlock_err;

  logic w_step_pulse;
  logic w_advance;
  logic w_flush;
  logic w_stall;

  assign w_step_pulse = i_debug_step & ~r_step_q;

  // In RUN with debug_en already high the cycle is frozen, matching HALT.
  assign w_advance = ((r_state == ST_RUN)  & ~i_debug_en) |
                     ((r_state == ST_HALT) & w_step_pulse);

  // A flush wins over a stall: the stalled ID instruction is wrong-path anyway.
  assign w_flush = w_advance & i_branch_taken;
  assign w_stall = w_advance & ~i_branch_taken & i_reg_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_INIT;
      r_rst_ctr      <= '0;
      r_stall_run    <= '0;
      r_step_q       <= 1'b0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
      r_deadlock_err <= 1'b0;
    end else begin
      r_step_q <= i_debug_step;

      case (r_state)
        ST_INIT: begin
          if (r_rst_ctr == RC_LAST) begin
            r_state <= i_debug_en ? ST_HALT : ST_RUN;
          end else begin
            r_rst_ctr <= r_rst_ctr + RC_ONE;
          end
        end
        ST_RUN: begin
          if (i_debug_en) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (!i_debug_en) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_INIT;
      endcase

      if (w_flush) begin
        if (r_flush_cnt != '1) begin
          r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
        r_stall_run <= '0;
      end else if (w_stall) begin
        if (r_stall_cnt != '1) begin
          r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
        if (r_stall_run != SR_LIMIT) begin
          r_stall_run <= r_stall_run + SR_ONE;
        end
        // This stall takes the run to STALL_MAX+1 (or it is already there).
        if (r_stall_run >= SR_MAX) begin
          r_deadlock_err <= 1'b1;
        end
      end else if (w_advance) begin
        r_stall_run <= '0;
      end
    end
  end

  // Outputs are combinational so that an async reset reaches the stages at once.
  always_comb begin
    o_if_rst  = 1'b0;
    o_if_en   = 1'b0;
    o_id_rst  = 1'b0;
    o_id_en   = 1'b0;
    o_exe_rst = 1'b0;
    o_exe_en  = 1'b0;
    o_mem_rst = 1'b0;
    o_mem_en  = 1'b0;
    o_wb_rst  = 1'b0;
    o_wb_en   = 1'b0;
    if (r_state == ST_INIT) begin
      o_if_rst  = 1'b1;
      o_id_rst  = 1'b1;
      o_exe_rst = 1'b1;
      o_mem_rst = 1'b1;
      o_wb_rst  = 1'b1;
    end else if (w_flush) begin
      // IF fetches the branch target; wrong-path IF/ID/EXE become bubbles.
      o_if_en   = 1'b1;
      o_id_rst  = 1'b1;
      o_exe_rst = 1'b1;
      o_mem_rst = 1'b1;
      o_wb_en   = 1'b1;
    end else if (w_stall) begin
      // PC and ID hold, a bubble enters EXE, older instructions drain.
      o_exe_rst = 1'b1;
      o_mem_en  = 1'b1;
      o_wb_en   = 1'b1;
    end else if (w_advance) begin
      o_if_en   = 1'b1;
      o_id_en   = 1'b1;
      o_exe_en  = 1'b1;
      o_mem_en  = 1'b1;
      o_wb_en   = 1'b1;
    end
  end

  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;
  assign o_deadlock_err = r_deadlock_err;

endmodule
